// File: rtl/check_compare.sv
// rtl/check_compare.sv - compares expected vs. captured vectors, counts pass/fail, logs failures
module check_compare #(
  parameter int ADDR_WIDTH = 20,
  parameter int STF_WIDTH  = 24,
  parameter int CHF_WIDTH  = STF_WIDTH + ADDR_WIDTH,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16,
  parameter int RES_WIDTH  = ADDR_WIDTH + 2 * STF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CHF_WIDTH-1:0] cfifo_data,
  input  logic                 cfifo_rdempty,
  output logic                 cfifo_rdreq,
  input  logic [STF_WIDTH-1:0] ofifo_data,
  input  logic                 ofifo_rdempty,
  output logic                 ofifo_rdreq,
  input  logic [SCC_WIDTH-1:0] sc_cmd,
  input  logic [SCD_WIDTH-1:0] sc_data,
  output logic                 sc_ready,
  output logic [RES_WIDTH-1:0] rfifo_data,
  output logic                 rfifo_wrreq,
  input  logic                 rfifo_wrfull,
  input  logic                 clear_counts,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic                 idle
);

  typedef enum logic [1:0] {IDLE, COMPARE, WR_RESULT} state_t;

  state_t                state;
  logic [STF_WIDTH-1:0]  expected;
  logic [STF_WIDTH-1:0]  actual;
  logic [STF_WIDTH-1:0]  diff;
  logic [STF_WIDTH-1:0]  bitmask;
  logic [ADDR_WIDTH-1:0] address;
  logic [STF_WIDTH-1:0]  diff_next;
  logic                  pop;
  logic                  pass_inc;
  logic                  fail_inc;

  // Both FIFOs are show-ahead: the pop strobe and the data latch share one cycle.
  assign pop         = (state == IDLE) && !cfifo_rdempty && !ofifo_rdempty && !reset;
  assign cfifo_rdreq = pop;
  assign ofifo_rdreq = pop;

  assign diff_next   = (expected ^ actual) & bitmask;
  assign pass_inc    = (state == COMPARE) && (diff_next == '0);
  assign fail_inc    = (state == COMPARE) && (diff_next != '0);

  assign rfifo_data  = {address, actual, diff};
  assign rfifo_wrreq = (state == WR_RESULT) && !rfifo_wrfull && !reset;
  assign sc_ready    = (state == IDLE);
  assign idle        = (state == IDLE) && cfifo_rdempty && ofifo_rdempty;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      expected <= '0;
      actual   <= '0;
      address  <= '0;
      diff     <= '0;
      bitmask  <= '1;
    end else begin
      if (sc_cmd == SCC_WIDTH'(1)) begin
        bitmask <= sc_data[STF_WIDTH-1:0];
      end
      case (state)
        IDLE: begin
          if (pop) begin
            expected <= cfifo_data[CHF_WIDTH-1 -: STF_WIDTH];
            address  <= cfifo_data[ADDR_WIDTH-1:0];
            actual   <= ofifo_data;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          diff  <= diff_next;
          state <= (diff_next == '0) ? IDLE : WR_RESULT;
        end
        WR_RESULT: begin
          if (!rfifo_wrfull) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counters stick at all ones; clear beats a same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset || clear_counts) begin
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      if (pass_inc && (pass_count != '1)) begin
        pass_count <= pass_count + CNT_WIDTH'(1);
      end
      if (fail_inc && (fail_count != '1)) begin
        fail_count <= fail_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_check_compare.sv
// tb/tb_check_compare.sv - self-checking bench for check_compare
module tb_check_compare;
  localparam int AW  = 20;
  localparam int SW  = 24;
  localparam int CHW = SW + AW;
  localparam int RW  = AW + 2 * SW;
  localparam int CW  = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [CHW-1:0] cfifo_data;
  logic           cfifo_rdempty;
  logic           cfifo_rdreq;
  logic [SW-1:0]  ofifo_data;
  logic           ofifo_rdempty;
  logic           ofifo_rdreq;
  logic [4:0]     sc_cmd;
  logic [23:0]    sc_data;
  logic           sc_ready;
  logic [RW-1:0]  rfifo_data;
  logic           rfifo_wrreq;
  logic           rfifo_wrfull;
  logic           clear_counts;
  logic [CW-1:0]  pass_count;
  logic [CW-1:0]  fail_count;
  logic           idle;

  always #5 clock = ~clock;

  check_compare #(.ADDR_WIDTH(AW), .STF_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .cfifo_data(cfifo_data), .cfifo_rdempty(cfifo_rdempty), .cfifo_rdreq(cfifo_rdreq),
    .ofifo_data(ofifo_data), .ofifo_rdempty(ofifo_rdempty), .ofifo_rdreq(ofifo_rdreq),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
    .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
    .clear_counts(clear_counts), .pass_count(pass_count), .fail_count(fail_count),
    .idle(idle)
  );

  logic [SW-1:0] cq_e[$];
  logic [AW-1:0] cq_a[$];
  logic [SW-1:0] oq[$];
  logic [RW-1:0] rq[$];
  int            pops;
  int            vectors;
  int            miscompares;

  task automatic refresh();
    cfifo_rdempty = (cq_e.size() == 0);
    cfifo_data    = cfifo_rdempty ? '0 : {cq_e[0], cq_a[0]};
    ofifo_rdempty = (oq.size() == 0);
    ofifo_data    = ofifo_rdempty ? '0 : oq[0];
  endtask

  task automatic push_pair(input logic [SW-1:0] e, input logic [AW-1:0] a, input logic [SW-1:0] act);
    cq_e.push_back(e);
    cq_a.push_back(a);
    oq.push_back(act);
    refresh();
  endtask

  // One clock: sample strobes at negedge, model the FIFOs at the edge.
  task automatic step();
    logic cp, op, wr;
    logic [RW-1:0] rd;
    @(negedge clock);
    cp = cfifo_rdreq;
    op = ofifo_rdreq;
    wr = rfifo_wrreq;
    rd = rfifo_data;
    vectors++;
    if (cp !== op) begin
      miscompares++;
      $display("FAIL pop_pairing cfifo_rdreq=%b ofifo_rdreq=%b", cp, op);
    end
    @(posedge clock);
    #1;
    if (cp === 1'b1 && cq_e.size() > 0) begin
      void'(cq_e.pop_front());
      void'(cq_a.pop_front());
      pops++;
    end
    if (op === 1'b1 && oq.size() > 0) void'(oq.pop_front());
    if (wr === 1'b1) rq.push_back(rd);
    refresh();
    #1;
  endtask

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(idle === 1'b1 && cq_e.size() == 0 && oq.size() == 0) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout got=%0d cycles expected<%0d", n, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    check("reset_pass_count", RW'(pass_count), RW'(0));
    check("reset_fail_count", RW'(fail_count), RW'(0));
    check("reset_wrreq", RW'(rfifo_wrreq), RW'(0));
    reset = 1'b0;
    step();
    check("reset_sc_ready", RW'(sc_ready), RW'(1));
    check("reset_idle", RW'(idle), RW'(1));
    check("reset_rdreq", RW'(cfifo_rdreq), RW'(0));
  endtask

  task automatic test_match();
    int p0 = pops;
    rq.delete();
    push_pair(24'h00A5A5, 20'h00010, 24'h00A5A5);
    step();
    check("match_one_pop", RW'(pops - p0), RW'(1));
    check("match_count_not_yet", RW'(pass_count), RW'(0));
    step();
    check("match_pass_count", RW'(pass_count), RW'(1));
    step();
    step();
    check("match_no_record", RW'(rq.size()), RW'(0));
    check("match_fail_count", RW'(fail_count), RW'(0));
  endtask

  task automatic test_mismatch();
    rq.delete();
    push_pair(24'h000001, 20'h00020, 24'h000003);
    step();
    step();
    check("mismatch_fail_count", RW'(fail_count), RW'(1));
    check("mismatch_no_early_record", RW'(rq.size()), RW'(0));
    step();
    check("mismatch_one_record", RW'(rq.size()), RW'(1));
    if (rq.size() > 0) check("mismatch_record", rq[0], {20'h00020, 24'h000003, 24'h000002});
    step();
    check("mismatch_single_write", RW'(rq.size()), RW'(1));
    check("mismatch_sc_ready", RW'(sc_ready), RW'(1));
  endtask

  task automatic test_mask();
    int pc = int'(pass_count);
    int fc = int'(fail_count);
    rq.delete();
    sc_cmd = 5'b00001;
    sc_data = 24'hFFFFFD;
    step();
    sc_cmd = 5'b00000;
    push_pair(24'h000001, 20'h00020, 24'h000003);
    step();
    step();
    check("mask_pass_count", RW'(pass_count), RW'(pc + 1));
    check("mask_fail_count", RW'(fail_count), RW'(fc));
    step();
    check("mask_no_record", RW'(rq.size()), RW'(0));
  endtask

  task automatic test_backpressure();
    int p0;
    sc_cmd = 5'b00001;
    sc_data = 24'hFFFFFF;
    step();
    sc_cmd = 5'b00000;
    rq.delete();
    rfifo_wrfull = 1'b1;
    push_pair(24'h0000F0, 20'h00005, 24'h00000F);
    step();
    step();
    push_pair(24'h000777, 20'h00006, 24'h000777);
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_sc_ready_low", RW'(sc_ready), RW'(0));
    end
    check("bp_no_write", RW'(rq.size()), RW'(0));
    check("bp_no_pop", RW'(pops - p0), RW'(0));
    rfifo_wrfull = 1'b0;
    step();
    check("bp_write_on_release", RW'(rq.size()), RW'(1));
    if (rq.size() > 0) check("bp_record", rq[0], {20'h00005, 24'h00000F, 24'h0000FF});
    check("bp_back_to_idle", RW'(sc_ready), RW'(1));
    drain(50);
  endtask

  task automatic test_one_sided();
    int p0 = pops;
    int pc = int'(pass_count);
    int fc = int'(fail_count);
    cq_e.push_back(24'h123456);
    cq_a.push_back(20'h00077);
    refresh();
    for (int i = 0; i < 10; i++) begin
      step();
      check("one_sided_idle_low", RW'(idle), RW'(0));
    end
    check("one_sided_no_pop", RW'(pops - p0), RW'(0));
    check("one_sided_counts", RW'({pass_count, fail_count}), RW'({CW'(pc), CW'(fc)}));
    oq.push_back(24'h123456);
    refresh();
    step();
    check("one_sided_pop", RW'(pops - p0), RW'(1));
    drain(50);
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      logic [SW-1:0] m;
      logic [RW-1:0] er[$];
      int ep, ef;
      m = (b == 0) ? 24'hFFFFFF : 24'($urandom);
      sc_cmd = 5'b00001;
      sc_data = m;
      step();
      sc_cmd = 5'b00000;
      ep = int'(pass_count);
      ef = int'(fail_count);
      rq.delete();
      for (int i = 0; i < 20; i++) begin
        logic [SW-1:0] e, a, d;
        logic [AW-1:0] ad;
        e  = 24'($urandom);
        ad = 20'($urandom);
        case ($urandom_range(0, 2))
          0:       a = e;
          1:       a = e ^ (24'd1 << $urandom_range(0, 23));
          default: a = 24'($urandom);
        endcase
        d = (e ^ a) & m;
        if (d == '0) ep++;
        else begin
          ef++;
          er.push_back({ad, a, d});
        end
        push_pair(e, ad, a);
      end
      begin
        int n = 0;
        while (!(idle === 1'b1 && cq_e.size() == 0 && oq.size() == 0) && n < 3000) begin
          rfifo_wrfull = ($urandom_range(0, 3) == 0);
          step();
          n++;
        end
        rfifo_wrfull = 1'b0;
        vectors++;
        if (n >= 3000) begin
          miscompares++;
          $display("FAIL random_timeout got=%0d cycles expected<3000", n);
        end
      end
      check("random_pass_count", RW'(pass_count), RW'(ep));
      check("random_fail_count", RW'(fail_count), RW'(ef));
      check("random_record_count", RW'(rq.size()), RW'(er.size()));
      for (int i = 0; i < er.size() && i < rq.size(); i++) check("random_record", rq[i], er[i]);
    end
  endtask

  task automatic test_saturation();
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    check("clear_counts", RW'({pass_count, fail_count}), RW'(0));
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      logic [SW-1:0] v;
      v = 24'($urandom);
      push_pair(v, 20'(i), v);
    end
    drain(3000);
    check("saturated_pass_count", RW'(pass_count), RW'({CW{1'b1}}));
    push_pair(24'h000042, 20'h00001, 24'h000042);
    step();
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    check("clear_beats_increment", RW'(pass_count), RW'(0));
  endtask

  task automatic test_reset_inflight();
    rq.delete();
    push_pair(24'h000001, 20'h00020, 24'h000003);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("reset_in_compare_fail", RW'(fail_count), RW'(0));
    rfifo_wrfull = 1'b1;
    push_pair(24'h000001, 20'h00020, 24'h000003);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rfifo_wrfull = 1'b0;
    step();
    step();
    check("reset_in_wr_no_record", RW'(rq.size()), RW'(0));
    check("reset_in_wr_counts", RW'({pass_count, fail_count}), RW'(0));
    push_pair(24'h000001, 20'h00020, 24'h000003);
    drain(50);
    check("reset_mask_restored", RW'(fail_count), RW'(1));
    if (rq.size() > 0) check("reset_mask_record", rq[0], {20'h00020, 24'h000003, 24'h000002});
    else check("reset_mask_record_missing", RW'(rq.size()), RW'(1));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    pops = 0;
    reset = 1'b1;
    sc_cmd = '0;
    sc_data = '0;
    rfifo_wrfull = 1'b0;
    clear_counts = 1'b0;
    refresh();
    test_reset();
    test_match();
    test_mismatch();
    test_mask();
    test_backpressure();
    test_one_sided();
    test_random();
    test_saturation();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
